// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_types
// Shared types for the memory responder: FSM state encoding, the decoded
// operation kind, the captured request record and a byte-lane merge helper
// used by the word array.
// -----------------------------------------------------------------------------
package mem_responder_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_ILLEGAL = 2'd2
    } op_e;

    // Snapshot of a request taken at acceptance; the live bus is never
    // consulted again until the response has been produced.
    typedef struct packed {
        op_e         op;
        logic [31:0] idx;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        oob;
    } req_t;

    localparam req_t REQ_NONE = '{
        op:    OP_READ,
        idx:   32'd0,
        wdata: 32'd0,
        be:    4'd0,
        oob:   1'b0
    };

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Multicycle memory bus between the CPU (master) and the responder (slave).
//   mem_read / mem_write   request strobes, held until mem_resp
//   mem_byte_enable [3:0]  write lane enables
//   mem_address [31:0]     byte address (word granular)
//   mem_wdata [31:0]       write data
//   mem_resp               one-cycle completion pulse
//   mem_rdata [31:0]       read data, valid with mem_resp
//   mem_err                one-cycle error pulse, coincident with mem_resp
// -----------------------------------------------------------------------------
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_responder_array.sv
// -----------------------------------------------------------------------------
// mem_responder_array
// Single-port byte-enabled word RAM, synchronous write, asynchronous read.
//   clk     clock
//   we      write strobe (one word, lanes selected by be)
//   be      byte lane enables
//   idx     word index shared by read and write
//   wdata   write data
//   rdata   combinational read of word idx
// Contents are deliberately not reset.
// -----------------------------------------------------------------------------
module mem_responder_array
    import mem_responder_types::*;
#(
    parameter int ADDR_WORDS_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [3:0]                 be,
    input  logic [ADDR_WORDS_LOG2-1:0] idx,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);
    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] word_d;

    // Merged word for a partial write: untouched lanes keep their old bytes.
    always_comb begin
        word_d = merge_lanes(mem_q[idx], wdata, be);
    end

    // Storage update.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= word_d;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the core's multicycle memory interface. Accepts
// one request at a time, waits LATENCY cycles, then pulses mem_resp (with
// mem_err on illegal access). Writes commit in the response cycle.
//   clk   clock
//   rst   synchronous active-high reset
//   bus   mem_responder_if slave port (request in, response out)
// Parameters: ADDR_WORDS_LOG2 (array depth), LATENCY (1..15),
//             BASE_ADDR (byte address of word 0, 4-byte aligned).
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_types::*;
#(
    parameter int          ADDR_WORDS_LOG2 = 10,
    parameter int          LATENCY         = 3,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam logic [31:0] DEPTH_W = 32'd1 << ADDR_WORDS_LOG2;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        resp_q, resp_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    req_t        new_req_s;
    req_t        eval_req_s;
    logic [31:0] off_s;
    logic        fail_s;
    logic [31:0] rsp_rdata_s;
    logic [31:0] arr_rdata_s;
    logic        we_s;

    // Decode the live bus into a request record (used only at acceptance).
    always_comb begin
        off_s           = bus.mem_address - BASE_ADDR;
        new_req_s.idx   = off_s >> 32'd2;
        new_req_s.oob   = (bus.mem_address < BASE_ADDR) || (new_req_s.idx >= DEPTH_W);
        new_req_s.wdata = bus.mem_wdata;
        new_req_s.be    = bus.mem_byte_enable;
        if (bus.mem_read && bus.mem_write) begin
            new_req_s.op = OP_ILLEGAL;
        end else if (bus.mem_write) begin
            new_req_s.op = OP_WRITE;
        end else begin
            new_req_s.op = OP_READ;
        end
    end

    // Response payload for the request about to enter RESP. With LATENCY=1
    // that request is still on the bus, otherwise it is the captured copy.
    always_comb begin
        eval_req_s = (state_q == IDLE) ? new_req_s : req_q;
        fail_s     = eval_req_s.oob || (eval_req_s.op == OP_ILLEGAL);
        case (eval_req_s.op)
            OP_READ:  rsp_rdata_s = fail_s ? 32'd0 : arr_rdata_s;
            OP_WRITE: rsp_rdata_s = fail_s ? 32'd0 : rdata_q;
            default:  rsp_rdata_s = 32'd0;
        endcase
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    req_d = new_req_s;
                    cnt_d = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        err_d   = fail_s;
                        rdata_d = rsp_rdata_s;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // Counter reaches 0 on the edge that enters RESP.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    err_d   = fail_s;
                    rdata_d = rsp_rdata_s;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                we_s    = (req_q.op == OP_WRITE) && !req_q.oob;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM and output registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= REQ_NONE;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    mem_responder_array #(
        .ADDR_WORDS_LOG2 (ADDR_WORDS_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (we_s && !rst),
        .be    (req_q.be),
        .idx   (eval_req_s.idx[ADDR_WORDS_LOG2-1:0]),
        .wdata (req_q.wdata),
        .rdata (arr_rdata_s)
    );

    assign bus.mem_resp  = resp_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (LATENCY 3/1/15, one with a non-zero
// base) driven from a shared request bus gated by a selector, checked against
// a word-array reference model.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_rd, req_wr;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata;
    int          sel;

    mem_responder_if if0 ();
    mem_responder_if if1 ();
    mem_responder_if if2 ();

    assign if0.mem_read = req_rd && (sel == 0);
    assign if0.mem_write = req_wr && (sel == 0);
    assign if1.mem_read = req_rd && (sel == 1);
    assign if1.mem_write = req_wr && (sel == 1);
    assign if2.mem_read = req_rd && (sel == 2);
    assign if2.mem_write = req_wr && (sel == 2);
    assign if0.mem_byte_enable = req_be;
    assign if1.mem_byte_enable = req_be;
    assign if2.mem_byte_enable = req_be;
    assign if0.mem_address = req_addr;
    assign if1.mem_address = req_addr;
    assign if2.mem_address = req_addr;
    assign if0.mem_wdata = req_wdata;
    assign if1.mem_wdata = req_wdata;
    assign if2.mem_wdata = req_wdata;

    mem_responder #(.ADDR_WORDS_LOG2(10), .LATENCY(3), .BASE_ADDR(32'h0000_0000))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    mem_responder #(.ADDR_WORDS_LOG2(4), .LATENCY(1), .BASE_ADDR(32'h0000_0000))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    mem_responder #(.ADDR_WORDS_LOG2(4), .LATENCY(15), .BASE_ADDR(32'h0000_0100))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic        resp_m, err_m;
    logic [31:0] rdata_m;
    assign resp_m  = (sel == 0) ? if0.mem_resp  : (sel == 1) ? if1.mem_resp  : if2.mem_resp;
    assign err_m   = (sel == 0) ? if0.mem_err   : (sel == 1) ? if1.mem_err   : if2.mem_err;
    assign rdata_m = (sel == 0) ? if0.mem_rdata : (sel == 1) ? if1.mem_rdata : if2.mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] model_mem [3][1024];
    logic [31:0] last_rd [3];
    int          exp_pulses [3];
    int          pulses [3];

    function automatic int lat_of(input int d);
        case (d)
            0:       return 3;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Count every response pulse seen on each responder.
    always @(negedge clk) begin
        if (!rst) begin
            if (if0.mem_resp) pulses[0]++;
            if (if1.mem_resp) pulses[1]++;
            if (if2.mem_resp) pulses[2]++;
        end
    end

    // One complete transaction on responder d; starts #1 after a posedge.
    task automatic access(input int d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] obs);
        logic [31:0] off, idx, exp_rdata, w;
        logic        oob, err;
        int          n, lat;
        bit          got;
        lat = lat_of(d);
        off = addr - base_of(d);
        idx = off >> 2;
        oob = (addr < base_of(d)) || (idx >= 32'(depth_of(d)));
        err = oob || (rd && wr);
        if (err)      exp_rdata = 32'd0;
        else if (rd)  exp_rdata = model_mem[d][idx];
        else          exp_rdata = last_rd[d];

        sel = d; req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0; got = 1'b0;
        while (!got && n < lat + 5) begin
            @(posedge clk); #1;
            n++;
            if (resp_m) got = 1'b1;
        end
        req_rd = 1'b0; req_wr = 1'b0;
        req_wdata = $urandom; req_be = 4'($urandom);
        obs = rdata_m;
        if (!got) begin
            check_val($sformatf("resp_timeout d%0d", d), 32'd0, 32'd1);
        end else begin
            exp_pulses[d]++;
            check_val($sformatf("latency d%0d a%h", d, addr), 32'(n), 32'(lat));
            check_val($sformatf("err d%0d a%h", d, addr), {31'd0, err_m}, {31'd0, err});
            check_val($sformatf("rdata d%0d a%h", d, addr), rdata_m, exp_rdata);
            if (!err && wr) begin
                w = model_mem[d][idx];
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                model_mem[d][idx] = w;
            end
            last_rd[d] = exp_rdata;
        end
        @(posedge clk); #1;
        check_val($sformatf("resp_drop d%0d", d), {31'd0, resp_m}, 32'd0);
    endtask

    logic [31:0] got_v;

    initial begin
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = 32'd0; exp_pulses[d] = 0; pulses[d] = 0;
        end
        sel = 0; req_rd = 1'b0; req_wr = 1'b0; req_be = 4'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_resp0", {31'd0, if0.mem_resp}, 32'd0);
        check_val("rst_err0", {31'd0, if0.mem_err}, 32'd0);
        check_val("rst_rdata0", if0.mem_rdata, 32'd0);
        check_val("rst_resp2", {31'd0, if2.mem_resp}, 32'd0);

        // Fill every array so later reads have defined contents.
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < depth_of(d); i++)
                access(d, 1'b0, 1'b1, base_of(d) + 32'(i * 4), $urandom, 4'hF, got_v);

        // Basic read
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got_v);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, got_v);
        check_val("basic_rd", got_v, 32'hDEADBEEF);

        // Byte-enabled write
        access(0, 1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, got_v);
        access(0, 1'b0, 1'b1, 32'h0A, 32'hAABB0000, 4'b1100, got_v);
        access(0, 1'b1, 1'b0, 32'h08, 32'd0, 4'h0, got_v);
        check_val("be_write", got_v, 32'hAABB3344);
        access(0, 1'b0, 1'b1, 32'h0C, 32'h55667788, 4'b0000, got_v);

        // Out of range and illegal
        access(0, 1'b1, 1'b0, 32'h1000, 32'd0, 4'h0, got_v);
        access(0, 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, got_v);
        access(0, 1'b1, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, got_v);
        access(0, 1'b1, 1'b0, 32'h0FFC, 32'd0, 4'h0, got_v);
        for (int i = 0; i < 1024; i++)
            access(0, 1'b1, 1'b0, 32'(i * 4), 32'd0, 4'h0, got_v);
        access(1, 1'b1, 1'b0, 32'h3C, 32'd0, 4'h0, got_v);
        access(1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, got_v);
        access(2, 1'b1, 1'b0, 32'h80, 32'd0, 4'h0, got_v);
        access(2, 1'b1, 1'b0, 32'h13C, 32'd0, 4'h0, got_v);
        access(2, 1'b0, 1'b1, 32'h140, 32'h87654321, 4'hF, got_v);

        // Reset one cycle into a write
        sel = 0; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'hFEEDFACE; req_be = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1; req_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = 32'd0;
        check_val("rst_mid_rdata", if0.mem_rdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_val("rst_mid_noresp", {31'd0, if0.mem_resp}, 32'd0);
            @(posedge clk); #1;
        end
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, got_v);

        // Back-to-back fetch/load on the shortest and longest latency
        for (int k = 0; k < 4; k++) begin
            access(1, 1'b1, 1'b0, 32'(k * 4), 32'd0, 4'h0, got_v);
            access(1, 1'b0, 1'b1, 32'(k * 4), $urandom, 4'($urandom), got_v);
            access(2, 1'b1, 1'b0, 32'h100 + 32'(k * 4), 32'd0, 4'h0, got_v);
            access(2, 1'b0, 1'b1, 32'h100 + 32'(k * 4), $urandom, 4'($urandom), got_v);
        end

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            int          d, pick;
            logic        rd, wr;
            logic [31:0] a;
            d    = $urandom_range(0, 2);
            pick = $urandom_range(0, 9);
            if (pick == 0)
                a = base_of(d) + 32'(depth_of(d) * 4) + 32'($urandom_range(0, 64));
            else if (pick == 1 && d == 2)
                a = 32'($urandom_range(0, 255));
            else
                a = base_of(d) + 32'($urandom_range(0, depth_of(d) - 1) * 4)
                    + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else begin
                rd = 1'($urandom_range(0, 1)); wr = !rd;
            end
            access(d, rd, wr, a, $urandom, 4'($urandom), got_v);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check_val($sformatf("pulse_count d%0d", d), 32'(pulses[d]), 32'(exp_pulses[d]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
